// File: rtl/loop_pipeline_ctrl_pkg.sv
// Shared types and defaults for the pipelined-loop controller.
package loop_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 32;

endpackage

// File: rtl/loop_pipeline_ctrl_timer.sv
// Issue interval timer: counts unstalled clocks since the last issue and
// reports due once II of them have elapsed (saturating).
module issue_interval_timer #(
  parameter int II = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic restart,
  input  logic stall,
  output logic due
);

  localparam int CW = $clog2(II + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CW'(II);
    end else if (!stall) begin
      if (restart)
        count_q <= CW'(1);
      else if (count_q < CW'(II))
        count_q <= count_q + CW'(1);
    end
  end

  assign due = (count_q >= CW'(II));

endmodule

// File: rtl/loop_pipeline_ctrl.sv
// Pipelined loop controller: issues one iteration every II clocks, drains DEPTH
// clocks, pulses done. Optional retire/in_flight tracking under LOOP_CTRL_INFLIGHT_EN.
module loop_pipeline_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int II    = 1,
  parameter int DEPTH = 4,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [CNT_W-1:0]           trip_count,
  input  logic                       stall,
  output logic                       iter_start,
  output logic [CNT_W-1:0]           iter_idx,
  output logic                       busy,
  output logic                       done
`ifdef LOOP_CTRL_INFLIGHT_EN
  ,
  output logic                       retire,
  output logic [$clog2(DEPTH+1)-1:0] in_flight
`endif
);

  localparam int DW = $clog2(DEPTH + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] trip_q;
  logic [CNT_W-1:0] idx_q;
  logic [DW-1:0]    drain_q;
  logic             zero_done_q;
  logic             due;
  logic             accept;
  logic             last_issue;
  logic             drain_end;

  // Start is only honoured in IDLE; a stalled cycle changes no state at all.
  assign accept     = (state_q == IDLE) && start && !stall;
  assign iter_start = (state_q == ISSUE) && due && !stall;
  assign last_issue = (idx_q == trip_q - CNT_W'(1));
  assign drain_end  = (state_q == DRAIN) && (drain_q == DW'(DEPTH - 1)) && !stall;
  assign done       = drain_end || zero_done_q;
  assign busy       = (state_q != IDLE);
  assign iter_idx   = idx_q;

  issue_interval_timer #(
    .II(II)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .restart(iter_start),
    .stall  (stall),
    .due    (due)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (trip_count != '0)) state_d = ISSUE;
      ISSUE:   if (iter_start && last_issue)     state_d = DRAIN;
      DRAIN:   if (drain_end)                    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      trip_q      <= '0;
      idx_q       <= '0;
      drain_q     <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= accept && (trip_count == '0);
      // idx never exceeds trip_q-1 before incrementing, so it cannot wrap.
      if (accept && (trip_count != '0)) begin
        trip_q <= trip_count;
        idx_q  <= '0;
      end else if (iter_start) begin
        idx_q  <= idx_q + CNT_W'(1);
      end
      if (iter_start && last_issue)
        drain_q <= '0;
      else if ((state_q == DRAIN) && !stall)
        drain_q <= drain_q + DW'(1);
    end
  end

`ifdef LOOP_CTRL_INFLIGHT_EN
  logic [DEPTH-1:0] retire_pipe_q;

  assign retire = retire_pipe_q[DEPTH-1] && !stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retire_pipe_q <= '0;
      in_flight     <= '0;
    end else if (!stall) begin
      retire_pipe_q[0] <= iter_start;
      for (int i = 1; i < DEPTH; i++)
        retire_pipe_q[i] <= retire_pipe_q[i-1];
      if (iter_start && !retire)
        in_flight <= in_flight + DW'(1);
      else if (!iter_start && retire)
        in_flight <= in_flight - DW'(1);
    end
  end
`endif

endmodule

// File: doc/loop_pipeline_ctrl.md
# loop_pipeline_ctrl

Controller for a pipelined loop. After a start pulse, it issues one iteration every II clocks until the latched trip count is exhausted. It then waits for the pipeline (depth DEPTH) to drain and pulses done. It sits downstream of the signal-timing builtins: it consumes the same "N clocks since last issue" and "condition at last issue" notions and turns them into the issue strobes that drive the loop datapath.

## Interface
- II, default 1: initiation interval in clocks, ≥1.
- DEPTH, default 4: pipeline latency in clocks from issue to retire, ≥1.
- CNT_W, default 32: width of trip count and iteration index.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low; clears all state immediately.
- start  in  1  one-cycle request to run a loop; sampled only in IDLE.
- trip_count  in  CNT_W  number of iterations; latched when start is accepted.
- stall  in  1  freezes all counters and suppresses issue while high.
- iter_start  out  1  pulse marking the cycle an iteration is issued.
- iter_idx  out  CNT_W  index of the issued iteration; valid with iter_start.
- busy  out  1  high from the first post-start cycle through the done cycle.
- done  out  1  one-cycle pulse when the last iteration retires.
- retire  out  1  (LOOP_CTRL_INFLIGHT_EN only) pulse DEPTH unstalled cycles after each iter_start.
- in_flight  out  $clog2(DEPTH+1)  (LOOP_CTRL_INFLIGHT_EN only) count of issued, unretired iterations.

## Operation
- States: IDLE, ISSUE, DRAIN.
- **IDLE, start=1, trip_count>0:** latch trip_count and go to ISSUE, with the issue timer forced to "due".
- **IDLE, start=1, trip_count=0:** no issue; done pulses the next cycle; stay in IDLE.
- **ISSUE:** iter_start=1 when the timer is due and stall=0.
  - On each issue, the timer restarts and iter_idx increments (it starts at 0).
  - The timer is due when II unstalled cycles have elapsed since the last issue.
  - When index trip_count-1 issues, go to DRAIN and clear the drain counter.
- **DRAIN:** the drain counter increments on each unstalled cycle. At DEPTH, pulse done and return to IDLE.
- **stall=1:** no state, timer, index, drain or retire-pipe change, and iter_start=0. An issue that was due is taken on the first unstalled cycle.
- **start outside IDLE:** ignored, with no queuing. start in the done cycle is also ignored; IDLE is entered on the following edge.
- Arithmetic:
  - Index and trip counters are unsigned CNT_W with no wrap. trip_count=2^CNT_W-1 is legal.
  - The drain counter is $clog2(DEPTH+1) bits.
- Reset values: iter_start=0, iter_idx=0, busy=0, done=0, retire=0, in_flight=0, state IDLE.
- Reset asserted mid-loop aborts it. No done is emitted, and in-flight tracking is discarded.

## Timing
- Let start be sampled high at edge E0, and let C1 be the cycle after E0. Issues occur at C1, C1+II, … up to C1+(N-1)·II, with no stalls.
- done occurs at C1+(N-1)·II+DEPTH, the same cycle as the last retire.
- Each stall cycle delays all later events by one cycle.
- iter_start, iter_idx and done are registered-state decodes with no combinational path from start or trip_count.
- stall→iter_start is combinational (masking only).
- A retire and an issue may fire in the same cycle. In that cycle in_flight is unchanged.

## Configuration
- **LOOP_CTRL_INFLIGHT_EN defined:**
  - adds a DEPTH-bit retire shift register (shifts on unstalled cycles, loaded with iter_start);
  - adds the retire and in_flight ports;
  - in_flight increments on issue and decrements on retire.
- **Not defined:** no shift register and the two ports are absent. Issue and done timing are identical either way.

## Structure
- Package loop_ctrl_pkg: the state enum (IDLE, ISSUE, DRAIN) and the default CNT_W constant.
- One sub-module, issue_interval_timer. It counts unstalled clocks since the last issue, has async active-low reset, a load-to-due input, and a due output at count ≥ II.

## Test plan
- II=2, DEPTH=3, trip_count=4 → iter_start at C1,C3,C5,C7 with idx 0..3; retire at C4,C6,C8,C10; done at C10; busy high C1–C10.
- trip_count=0 → done at C1, no iter_start, busy stays 0.
- II=1, DEPTH=2, trip_count=3, stall high during C2 only → issues at C1,C3,C4; done at C6; in_flight peaks at 2.
- start pulsed again at C3 of a running trip_count=4 loop → ignored; exactly 4 issues and one done.
- rst pulled low at C4 of II=2, DEPTH=3, trip_count=4 → all outputs 0 immediately, no done. A fresh start afterwards runs cleanly from idx 0.
- II=1, DEPTH=1, trip_count=1 → issue at C1, retire and done at C2; back-to-back start at C3 → issue at C4.
